// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, fetches one word over req/ready, presents it to decode until acked.
// Fetch result one cycle after imem_ready; a request is held indefinitely while imem_ready is low. IFETCH_DELAY_SLOT_EN adds a MIPS branch delay slot.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        br_taken,
  input  logic        jump
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;

  logic        w_load;
  logic        w_take;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_br_tgt;
  logic [31:0] w_redirect;
  logic [31:0] w_fetch_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_tgt   = w_pc_plus4 + w_br_off;
  assign w_jump_tgt = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

  // Jump outranks branch when the control path asserts both.
  always_comb begin
    w_redirect = w_pc_plus4;
    if (jump) begin
      w_redirect = w_jump_tgt;
    end else if (br_taken) begin
      w_redirect = w_br_tgt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          w_state_nxt = S_HOLD;
          w_load      = 1'b1;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          w_state_nxt = S_REQ;
          w_take      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef IFETCH_DELAY_SLOT_EN
  logic        r_pending;
  logic [31:0] r_pending_target;
  logic        w_arm;

  // The instruction after a taken branch/jump always executes; the redirect lands on the ack after it.
  assign w_arm = w_take & ~r_pending & (jump | br_taken);

  always_comb begin
    w_fetch_pc = w_pc_plus4;
    if (r_pending) begin
      w_fetch_pc = r_pending_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending        <= 1'b0;
      r_pending_target <= 32'd0;
    end else if (w_take) begin
      r_pending <= w_arm;
      if (w_arm) begin
        r_pending_target <= w_redirect;
      end
    end
  end
`else
  assign w_fetch_pc = w_redirect;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_imem_req <= (w_state_nxt == S_REQ);
      if (w_load) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_take) begin
        r_instr_valid <= 1'b0;
        r_pc          <= w_fetch_pc;
        r_imem_addr   <= w_fetch_pc;
      end
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign opcode      = r_instr[31:26];
  assign funct       = r_instr[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; expected fetch addresses worked out by hand per instruction.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ack;
  logic        br_taken;
  logic        jump;

  int total = 0;
  int bad   = 0;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .br_taken    (br_taken),
    .jump        (jump)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a request, checks its address stays put for `waits` cycles, then returns `word`.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      tick();
      check("wait_addr", imem_addr, addr);
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("instr", instr, word);
    check("valid", 32'(instr_valid), 32'd1);
    check("pc", pc, addr);
    check("req_drop", 32'(imem_req), 32'd0);
  endtask

  task automatic ack(input logic br, input logic jmp);
    instr_ack = 1'b1;
    br_taken  = br;
    jump      = jmp;
    tick();
    instr_ack = 1'b0;
    br_taken  = 1'b0;
    jump      = 1'b0;
    check("ack_valid", 32'(instr_valid), 32'd0);
    check("ack_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    instr_ack  = 1'b0;
    br_taken   = 1'b0;
    jump       = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0000_3000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, 32'h0000_3000);
    rst = 1'b0;
    tick();
    check("idle_to_req", 32'(imem_req), 32'd1);

    fetch(32'h0000_3000, 32'h2401_0005, 2);
    check("opcode_addiu", 32'(opcode), 32'h09);
    check("funct_addiu", 32'(funct), 32'h05);
    check("pc_plus4_3000", pc_plus4, 32'h0000_3004);
    ack(1'b0, 1'b0);

    fetch(32'h0000_3004, 32'h1000_FFFF, 0);
    check("opcode_beq", 32'(opcode), 32'h04);
    check("funct_beq", 32'(funct), 32'h3F);
    ack(1'b1, 1'b0);
`ifdef IFETCH_DELAY_SLOT_EN
    fetch(32'h0000_3008, 32'h0000_0000, 1);
    ack(1'b0, 1'b1);
`endif
    fetch(32'h0000_3004, 32'h1000_FFFF, 1);
    ack(1'b0, 1'b0);

    fetch(32'h0000_3008, 32'h0800_0C00, 0);
    check("opcode_j", 32'(opcode), 32'h02);
    ack(1'b1, 1'b1);
`ifdef IFETCH_DELAY_SLOT_EN
    fetch(32'h0000_300C, 32'h0000_0000, 0);
    ack(1'b0, 1'b0);
`endif

    fetch(32'h0000_3000, 32'h1000_8000, 3);
    ack(1'b1, 1'b0);
`ifdef IFETCH_DELAY_SLOT_EN
    fetch(32'h0000_3004, 32'h0000_0000, 0);
    ack(1'b0, 1'b0);
`endif
    fetch(32'hFFFE_3004, 32'h0BFF_FFFF, 0);
    check("pc_plus4_hi", pc_plus4, 32'hFFFE_3008);
    ack(1'b0, 1'b1);
`ifdef IFETCH_DELAY_SLOT_EN
    fetch(32'hFFFE_3008, 32'h0000_0000, 0);
    ack(1'b0, 1'b0);
`endif
    fetch(32'hFFFF_FFFC, 32'h0000_0020, 0);
    check("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
    check("funct_add", 32'(funct), 32'h20);

    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    tick();
    imem_ready = 1'b0;
    check("hold_instr", instr, 32'h0000_0020);
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_req", 32'(imem_req), 32'd0);
    ack(1'b0, 1'b0);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    tick();
    rst        = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick();
    check("rst_req_drop", 32'(imem_req), 32'd0);
    check("rst_req_valid", 32'(instr_valid), 32'd0);
    check("rst_req_addr", imem_addr, 32'h0000_3000);
    tick();
    check("rst_late_ready", 32'(instr_valid), 32'd0);
    rst        = 1'b0;
    imem_ready = 1'b0;
    tick();
    check("post_rst_valid", 32'(instr_valid), 32'd0);

    fetch(32'h0000_3000, 32'h0800_0C10, 0);
    ack(1'b0, 1'b1);
`ifdef IFETCH_DELAY_SLOT_EN
    check("jump_pend_addr", imem_addr, 32'h0000_3004);
`else
    check("jump_far_addr", imem_addr, 32'h0000_3040);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch(32'h0000_3000, 32'h2401_0005, 0);
    rst       = 1'b1;
    instr_ack = 1'b1;
    jump      = 1'b1;
    tick();
    rst       = 1'b0;
    instr_ack = 1'b0;
    jump      = 1'b0;
    check("rst_ack_valid", 32'(instr_valid), 32'd0);
    check("rst_ack_pc", pc, 32'h0000_3000);
    check("rst_ack_req", 32'(imem_req), 32'd0);

    fetch(32'h0000_3000, 32'h0000_0000, 0);
    ack(1'b0, 1'b0);
    check("pend_cleared", imem_addr, 32'h0000_3004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
